// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, fixed address/bank values and
// the auto-refresh controller state type.
package sdram_pkg;

  typedef logic [3:0] sdram_cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_AREF      = 4'b0001;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_MRS       = 4'b0000;

  // A10 high selects precharge-all
  localparam logic [10:0] ADDR_PRECHARGE_ALL = 11'h7ff;
  localparam logic [1:0]  BA_DEFAULT         = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCHG,
    S_TRP,
    S_AREF,
    S_TRC,
    S_END
  } aref_state_t;

endpackage

// File: rtl/sdram_aref_ctrl_if.sv
// Refresh request/grant handshake and refresh command bus between the
// auto-refresh controller (slave) and the SDRAM command arbiter (master).
interface sdram_aref_ctrl_if;
  import sdram_pkg::*;

  logic        aref_en;
  logic        aref_req;
  logic        aref_end;
  sdram_cmd_t  aref_cmd;
  logic [1:0]  aref_ba;
  logic [10:0] aref_addr;
  logic        ref_overrun;

  modport master (
    output aref_en,
    input  aref_req,
    input  aref_end,
    input  aref_cmd,
    input  aref_ba,
    input  aref_addr,
    input  ref_overrun
  );

  modport slave (
    input  aref_en,
    output aref_req,
    output aref_end,
    output aref_cmd,
    output aref_ba,
    output aref_addr,
    output ref_overrun
  );

endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer: periodic tick, pending refresh request with
// grant-clear, and overrun pulse when a tick finds a request still pending.
module sdram_ref_timer #(
  parameter int unsigned REF_INTERVAL = 750
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic init_end,
  input  logic clr,
  output logic aref_req,
  output logic ref_overrun
);

  localparam int unsigned CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_ref;
  logic          tick;

  assign tick = init_end && (cnt_ref == CNT_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_ref <= '0;
    end else if (!init_end || tick) begin
      cnt_ref <= '0;
    end else begin
      cnt_ref <= cnt_ref + 1'b1;
    end
  end

  // A tick coinciding with the grant re-arms the request: the refresh being
  // started was owed for the previous interval, this one is still owed.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      aref_req    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      ref_overrun <= tick && aref_req && !clr;
      if (!init_end) begin
        aref_req <= 1'b0;
      end else if (tick) begin
        aref_req <= 1'b1;
      end else if (clr) begin
        aref_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_aref_ctrl.sv
// Auto-refresh controller: requests refresh from the arbiter and, once
// granted, issues PRECHARGE-ALL followed by AREF_NUM AUTO_REFRESH commands.
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 750,
  parameter int unsigned TRP_CLK      = 2,
  parameter int unsigned TRC_CLK      = 7,
  parameter int unsigned AREF_NUM     = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                init_end,
  sdram_aref_ctrl_if.slave    aref
);

  localparam int unsigned CLK_MAX  = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int unsigned CLK_W    = $clog2(CLK_MAX + 1);
  localparam int unsigned AW       = $clog2(AREF_NUM + 1);
  localparam int unsigned TRP_WAIT = (TRP_CLK > 1) ? TRP_CLK - 2 : 0;
  localparam int unsigned TRC_WAIT = TRC_CLK - 2;

  localparam logic [CLK_W-1:0] TRP_LAST = CLK_W'(TRP_WAIT);
  localparam logic [CLK_W-1:0] TRC_LAST = CLK_W'(TRC_WAIT);
  localparam logic [AW-1:0]    AREF_MAX = AW'(AREF_NUM);

  aref_state_t      state;
  aref_state_t      state_nxt;
  logic [CLK_W-1:0] cnt_clk;
  logic [AW-1:0]    cnt_aref;
  sdram_cmd_t       cmd;
  logic             grant;

  // Request clears only when IDLE accepts the grant, so a held aref_en does
  // not swallow a request re-armed during the running sequence.
  assign grant = (state == S_IDLE) && aref.aref_en && init_end;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .init_end    (init_end),
    .clr         (grant),
    .aref_req    (aref.aref_req),
    .ref_overrun (aref.ref_overrun)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_clk <= '0;
    end else if (state_nxt != state) begin
      cnt_clk <= '0;
    end else if (state == S_TRP || state == S_TRC) begin
      cnt_clk <= cnt_clk + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_aref <= '0;
    end else if (!init_end || state == S_END) begin
      cnt_aref <= '0;
    end else if (state == S_AREF) begin
      cnt_aref <= cnt_aref + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd       = CMD_NOP;
    unique case (state)
      S_IDLE: begin
        if (aref.aref_en) begin
          state_nxt = S_PCHG;
        end
      end
      S_PCHG: begin
        cmd       = CMD_PRECHARGE;
        state_nxt = (TRP_CLK > 1) ? S_TRP : S_AREF;
      end
      S_TRP: begin
        if (cnt_clk == TRP_LAST) begin
          state_nxt = S_AREF;
        end
      end
      S_AREF: begin
        cmd       = CMD_AREF;
        state_nxt = S_TRC;
      end
      S_TRC: begin
        if (cnt_clk == TRC_LAST) begin
          state_nxt = (cnt_aref < AREF_MAX) ? S_AREF : S_END;
        end
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (!init_end) begin
      state_nxt = S_IDLE;
    end
  end

  assign aref.aref_cmd  = cmd;
  assign aref.aref_end  = (state == S_END);
  assign aref.aref_ba   = BA_DEFAULT;
  assign aref.aref_addr = ADDR_PRECHARGE_ALL;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Scoreboard bench for sdram_aref_ctrl: a cycle-level reference model queues
// expected outputs, a monitor pops and compares them one cycle at a time.
module tb_sdram_aref_ctrl;
  import sdram_pkg::*;

  localparam int unsigned REF  = 750;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRC  = 7;
  localparam int unsigned NREF = 2;
  localparam int unsigned LEN  = TRP + NREF * TRC + 1;

  typedef struct packed {
    logic       req;
    logic       endp;
    logic       ovr;
    logic [3:0] cmd;
  } exp_t;

  logic sys_clk  = 1'b0;
  logic sys_rst;
  logic init_end;

  sdram_aref_ctrl_if bus ();

  sdram_aref_ctrl #(
    .REF_INTERVAL (REF),
    .TRP_CLK      (TRP),
    .TRC_CLK      (TRC),
    .AREF_NUM     (NREF)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .init_end (init_end),
    .aref     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Offsets within a granted sequence where AUTO_REFRESH is due
  function automatic bit is_aref(input int unsigned o);
    return (o >= TRP) && (((o - TRP) % TRC) == 0) && (((o - TRP) / TRC) < NREF);
  endfunction

  // Reference model: elapsed-cycle arithmetic and sequence offset
  int unsigned since_init = 0;
  int unsigned off        = 0;
  bit          req_m      = 1'b0;
  bit          active     = 1'b0;
  bit          mdl_tick;
  bit          mdl_grant;
  exp_t        mdl_e;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      since_init = 0;
      req_m      = 1'b0;
      active     = 1'b0;
      off        = 0;
      mdl_e.req  = 1'b0;
      mdl_e.endp = 1'b0;
      mdl_e.ovr  = 1'b0;
      mdl_e.cmd  = CMD_NOP;
    end else begin
      mdl_tick  = init_end && ((since_init % REF) == REF - 1);
      mdl_grant = init_end && !active && (bus.aref_en === 1'b1);
      mdl_e.ovr = mdl_tick && req_m && !mdl_grant;
      if (!init_end)      req_m = 1'b0;
      else if (mdl_tick)  req_m = 1'b1;
      else if (mdl_grant) req_m = 1'b0;
      since_init = init_end ? since_init + 1 : 0;
      if (!init_end) begin
        active = 1'b0;
      end else if (active) begin
        if (off == LEN - 1) active = 1'b0;
        else off++;
      end else if (mdl_grant) begin
        active = 1'b1;
        off    = 0;
      end
      mdl_e.req  = req_m;
      mdl_e.endp = active && (off == LEN - 1);
      if (!active)          mdl_e.cmd = CMD_NOP;
      else if (off == 0)    mdl_e.cmd = CMD_PRECHARGE;
      else if (is_aref(off)) mdl_e.cmd = CMD_AREF;
      else                  mdl_e.cmd = CMD_NOP;
    end
    exp_q.push_back(mdl_e);
  end

  exp_t mon_e;
  always @(posedge sys_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("cmd", 32'(bus.aref_cmd), 32'(mon_e.cmd));
      chk("aref_req", 32'(bus.aref_req), 32'(mon_e.req));
      chk("aref_end", 32'(bus.aref_end), 32'(mon_e.endp));
      chk("ref_overrun", 32'(bus.ref_overrun), 32'(mon_e.ovr));
      chk("ba_addr", 32'({bus.aref_ba, bus.aref_addr}), 32'({2'b11, 11'h7ff}));
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_req(input int unsigned bound, output int unsigned waited);
    waited = 0;
    while (bus.aref_req !== 1'b1 && waited < bound) begin
      @(negedge sys_clk);
      waited++;
    end
    if (bus.aref_req !== 1'b1) chk("req_timeout", 32'(bus.aref_req), 32'd1);
  endtask

  task automatic run_seq();
    bit seen;
    seen = 1'b0;
    bus.aref_en = 1'b1;
    for (int i = 0; i < int'(LEN) + 4 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.aref_end === 1'b1) seen = 1'b1;
    end
    bus.aref_en = 1'b0;
    chk("aref_end_seen", 32'(seen), 32'd1);
  endtask

  task automatic grant_to_pchg();
    bus.aref_en = 1'b1;
    for (int i = 0; i < 4 && bus.aref_cmd !== CMD_PRECHARGE; i++) @(negedge sys_clk);
    chk("pchg_seen", 32'(bus.aref_cmd), 32'(CMD_PRECHARGE));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"}, 32'(bus.aref_cmd), 32'(CMD_NOP));
    chk({tag, "_req"}, 32'(bus.aref_req), 32'd0);
    chk({tag, "_end"}, 32'(bus.aref_end), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.ref_overrun), 32'd0);
    chk({tag, "_ba_addr"}, 32'({bus.aref_ba, bus.aref_addr}), 32'({2'b11, 11'h7ff}));
  endtask

  int unsigned n;
  int unsigned n_ovr;

  initial begin
    sys_rst     = 1'b1;
    init_end    = 1'b0;
    bus.aref_en = 1'b0;
    cyc(3);
    chk_reset_vals("reset");

    // Interval from init_end to first request
    sys_rst  = 1'b0;
    init_end = 1'b1;
    wait_req(REF + 20, n);
    chk("req_latency", n, REF);
    cyc(3);
    chk("req_holds", 32'(bus.aref_req), 32'd1);

    // Normal granted sequence
    run_seq();
    chk("req_cleared_by_grant", 32'(bus.aref_req), 32'd0);

    // Withheld grant: two overruns merge into one pending request
    wait_req(REF + 20, n);
    n_ovr = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge sys_clk);
      if (bus.ref_overrun === 1'b1) n_ovr++;
    end
    chk("overrun_count", n_ovr, 32'd2);
    chk("req_pending", 32'(bus.aref_req), 32'd1);
    run_seq();
    chk("req_after_merged_seq", 32'(bus.aref_req), 32'd0);

    // Grant landing exactly on a tick with a request already pending
    wait_req(REF + 20, n);
    for (int i = 0; i < int'(REF) + 5 && !(init_end && (since_init % REF) == REF - 1); i++)
      @(negedge sys_clk);
    bus.aref_en = 1'b1;
    @(negedge sys_clk);
    chk("tick_grant_req", 32'(bus.aref_req), 32'd1);
    chk("tick_grant_ovr", 32'(bus.ref_overrun), 32'd0);
    run_seq();
    chk("req_pending_after_seq", 32'(bus.aref_req), 32'd1);
    run_seq();
    chk("req_cleared_second", 32'(bus.aref_req), 32'd0);

    // init_end drop at c5 aborts the sequence
    wait_req(REF + 20, n);
    grant_to_pchg();
    cyc(5);
    init_end    = 1'b0;
    bus.aref_en = 1'b0;
    @(negedge sys_clk);
    chk("abort_cmd", 32'(bus.aref_cmd), 32'(CMD_NOP));
    chk("abort_req", 32'(bus.aref_req), 32'd0);
    chk("abort_end", 32'(bus.aref_end), 32'd0);
    cyc(3);
    init_end = 1'b1;
    wait_req(REF + 20, n);
    chk("req_after_init_restore", n, REF);

    // Asynchronous reset at c9
    grant_to_pchg();
    cyc(9);
    chk("c9_aref", 32'(bus.aref_cmd), 32'(CMD_AREF));
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    bus.aref_en = 1'b0;
    cyc(3);
    sys_rst = 1'b0;

    // Randomised grant delays and aborts
    for (int it = 0; it < 6; it++) begin
      wait_req(REF + 20, n);
      cyc($urandom_range(0, 900));
      if ($urandom_range(0, 3) == 0) begin
        grant_to_pchg();
        cyc($urandom_range(1, LEN - 2));
        init_end    = 1'b0;
        bus.aref_en = 1'b0;
        cyc($urandom_range(1, 20));
        init_end = 1'b1;
      end else begin
        run_seq();
      end
    end

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
Auto-refresh controller for the 32-bit SDRAM interface behind the SDRAM command arbiter. It times the refresh interval and raises a refresh request to the arbiter. Once granted, it drives the PRECHARGE-ALL / AUTO-REFRESH command sequence onto the arbiter's refresh command inputs, then signals completion so the arbiter returns to arbitration.

Parameters:
REF_INTERVAL, 750, refresh request period in sys_clk cycles (7.5 us at 100 MHz)
TRP_CLK, 2, cycles from PRECHARGE to the first AUTO_REFRESH (tRP), min 1
TRC_CLK, 7, cycles from one AUTO_REFRESH to the next command (tRC), min 2
AREF_NUM, 2, AUTO_REFRESH commands per granted sequence, 1..4

Ports:
sys_clk  in  1  system clock, all logic on its rising edge
sys_rst  in  1  asynchronous, active-high reset
init_end  in  1  SDRAM init complete; level, high while the device is usable
aref_en  in  1  grant from arbiter; high from the cycle after the grant until the cycle after aref_end
aref_req  out  1  refresh request to arbiter, registered
aref_end  out  1  one-cycle pulse, last cycle of the refresh sequence
aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REF 4'b0001
aref_ba  out  2  bank address, constant 2'b11
aref_addr  out  11  address bus, constant 11'h7ff (A10=1 selects precharge-all)
ref_overrun  out  1  one-cycle pulse: interval expired while a request was already pending

Behaviour:
- Reset values:
  - aref_req=0, aref_end=0, ref_overrun=0.
  - aref_cmd=NOP, aref_ba=2'b11, aref_addr=11'h7ff.
  - FSM=IDLE; all counters 0.
- Refresh timer cnt_ref:
  - Held at 0 while init_end=0.
  - Otherwise increments each cycle and wraps REF_INTERVAL-1 -> 0; the wrap cycle is "tick".
- aref_req:
  - Set on tick.
  - Cleared at the edge where aref_en=1 is sampled.
  - If tick and aref_en=1 occur in the same cycle, set wins (a new request stays pending).
  - If tick occurs while aref_req=1 and it is not being cleared, pulse ref_overrun. The request is merged, not counted.
- FSM states IDLE, PCHG, TRP, AREF, TRC, END. cnt_clk resets on every state change.
  - IDLE: cmd NOP. aref_en=1 -> PCHG (PRECHARGE appears one cycle after aref_en is first seen).
  - PCHG: cmd PRECHARGE for 1 cycle -> TRP.
  - TRP: cmd NOP for TRP_CLK-1 cycles -> AREF. If TRP_CLK=1, go straight to AREF.
  - AREF: cmd AUTO_REF for 1 cycle, increments cnt_aref -> TRC.
  - TRC: cmd NOP for TRC_CLK-1 cycles. Then AREF if cnt_aref<AREF_NUM, else END.
  - END: cmd NOP, aref_end=1 for 1 cycle, cnt_aref cleared -> IDLE.
- aref_end decodes state==END. The arbiter samples aref_end and drops aref_en at the same edge, so IDLE never re-triggers on a stale grant.
- Sequence length from PCHG to END inclusive: 1 + (TRP_CLK-1) + AREF_NUM*TRC_CLK + 1. With defaults this is 17 cycles:
  - PRECHARGE at c0.
  - AUTO_REF at c2 and c9.
  - END at c16.
- aref_en dropping mid-sequence is ignored; the sequence always completes. Timing must never be truncated.
- init_end=0 in any state: FSM -> IDLE and aref_req -> 0 at the next edge, cmd NOP. No aref_end is issued.
- sys_rst asserted mid-sequence: all outputs return to reset values immediately (asynchronous).
- aref_ba and aref_addr are constant in every state.

Decomposition:
- Shared package sdram_pkg holds:
  - Command encodings CMD_NOP, CMD_PRECHARGE, CMD_AREF (plus CMD_ACTIVE, CMD_WRITE, CMD_READ, CMD_MRS for the sibling blocks).
  - Precharge-all address constant 11'h7ff.
  - Bank-default constant 2'b11.
  - This block's FSM state enum.
- One sub-module is natural: sdram_ref_timer, holding cnt_ref, tick, and the aref_req set/clear/overrun logic. The command FSM stays in the top.

Test Plan:
- Release reset with init_end=1, aref_en held 0 -> aref_req rises exactly 750 cycles after init_end, then holds.
- Grant aref_en one cycle after aref_req -> aref_req clears at the next edge. aref_cmd shows:
  - PRECHARGE at c0, NOP at c1.
  - AUTO_REF at c2, NOP at c3-c8.
  - AUTO_REF at c9, NOP at c10-c16.
  - aref_end=1 at c16 only, then IDLE with NOP.
- Withhold aref_en for 1600 cycles -> aref_req stays 1 and ref_overrun pulses at cycles 1500 and 2250 of the timer. After the grant, exactly one 17-cycle sequence runs.
- Assert the grant in the tick cycle -> aref_req remains 1 after the edge and ref_overrun stays 0. A second sequence starts after the first completes and the arbiter re-grants.
- Drop init_end at c5 of a sequence -> next cycle FSM=IDLE, cmd=NOP, aref_req=0, no aref_end, cnt_ref=0. Raise sys_rst at c9 -> outputs return to reset values within the same cycle.
- Throughout all scenarios, aref_ba is 2'b11 and aref_addr is 11'h7ff; no command other than NOP appears outside a granted sequence.
